multicycle_ctrl32: RTL and testbench

Multi-cycle sequencing controller for the MIPS32 (Minisys) CPU. It replaces single-cycle decode with a registered state machine: fetch, decode, execute, memory and write-back. In each state it drives the step enables and mux selects for the shared PC, IR, register file, ALU and data memory/IO. It sits between the instruction register (source of opcode/funct) and the datapath, and stretches memory steps via a ready handshake for slow IO.

---
 rtl/mips_ctrl_pkg.sv | 46 ++++
 rtl/ctrl_decode32.sv | 31 +++
 rtl/multicycle_ctrl32.sv | 160 ++++++++++++++++
 tb/tb_multicycle_ctrl32.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS32 (Minisys) controller:
// states, opcodes, instruction classes and datapath select codes.
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] FUNCT_JR = 6'h08;

  typedef enum logic [3:0] {
    CLS_RTYPE, CLS_JR, CLS_J, CLS_JAL, CLS_BEQ,
    CLS_BNE, CLS_ITYPE, CLS_LW, CLS_SW, CLS_ILLEGAL
  } class_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;
  localparam logic [1:0] ALU_ITYPE = 2'b11;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_RS     = 2'd3;

  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;

  // sll, srl, sra, sllv, srlv, srav
  function automatic logic is_shift(input logic [5:0] funct);
    return funct inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
  endfunction

endpackage

// File: rtl/ctrl_decode32.sv
// Combinational instruction classifier: opcode/funct to class and shift flag.
module ctrl_decode32
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output class_t     cls,
  output logic       sftmd
);

  // NOTE: every output gets a default before the case so no path leaves
  // a value unassigned, which would otherwise infer a latch.
  always_comb begin
    cls   = CLS_ILLEGAL;
    sftmd = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        cls   = (funct == FUNCT_JR) ? CLS_JR : CLS_RTYPE;
        sftmd = is_shift(funct);
      end
      OP_J:    cls = CLS_J;
      OP_JAL:  cls = CLS_JAL;
      OP_BEQ:  cls = CLS_BEQ;
      OP_BNE:  cls = CLS_BNE;
      OP_LW:   cls = CLS_LW;
      OP_SW:   cls = CLS_SW;
      default: if (opcode[5:3] == 3'b001) cls = CLS_ITYPE;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl32.sv
// Multi-cycle sequencing controller: IF/ID/EX/MEM/WB state machine driving
// the shared datapath enables and selects, with a ready-stretched MEM step.
module multicycle_ctrl32
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [2:0] state,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic       mem_to_reg,
  output logic       mem_read,
  output logic       mem_write,
  output logic       alu_src,
  output logic [1:0] alu_op,
  output logic       sftmd,
  output logic       instr_done,
  output logic       illegal,
  output logic       mem_timeout
);

  localparam logic [7:0] WAIT_MAX = 8'(MEM_WAIT_MAX);

  state_t     state_q, state_d;
  class_t     class_q, dec_class, cls;
  logic       sft_q, dec_sftmd;
  logic [7:0] wait_q, wait_nx;
  logic       illegal_q, timeout_q;

  ctrl_decode32 u_decode (
    .opcode (opcode),
    .funct  (funct),
    .cls    (dec_class),
    .sftmd  (dec_sftmd)
  );

  // ID acts on the live decode; later states use the class captured in ID.
  assign cls     = (state_q == S_ID) ? dec_class : class_q;
  assign wait_nx = wait_q + 8'd1;

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IF;
      class_q   <= CLS_RTYPE;
      sft_q     <= 1'b0;
      wait_q    <= 8'd0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_ID) begin
        class_q <= dec_class;
        sft_q   <= dec_sftmd;
        if (dec_class == CLS_ILLEGAL) illegal_q <= 1'b1;
      end
      // MEM is only entered from EX, so clearing in EX is clearing on entry.
      if (state_q == S_EX) begin
        wait_q <= 8'd0;
      end else if (state_q == S_MEM && !mem_ready) begin
        if (wait_q != 8'hff) wait_q <= wait_nx;
        if (wait_nx == WAIT_MAX) timeout_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_PLUS4;
    reg_write  = 1'b0;
    reg_dst    = DST_RT;
    mem_to_reg = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_src    = 1'b0;
    alu_op     = ALU_ADD;
    sftmd      = 1'b0;
    case (state_q)
      S_IF: begin
        ir_write = 1'b1;
        pc_write = 1'b1;
        state_d  = S_ID;
      end
      S_ID: begin
        state_d = S_EX;
        case (cls)
          CLS_J:       begin pc_write = 1'b1; pc_src = PC_JUMP; state_d = S_IF; end
          CLS_JR:      begin pc_write = 1'b1; pc_src = PC_RS;   state_d = S_IF; end
          CLS_JAL: begin
            pc_write  = 1'b1;
            pc_src    = PC_JUMP;
            reg_write = 1'b1;
            reg_dst   = DST_RA;
            state_d   = S_IF;
          end
          CLS_ILLEGAL: state_d = S_IF;
          default:     ;
        endcase
      end
      S_EX: begin
        case (cls)
          CLS_RTYPE: begin alu_op = ALU_RTYPE; sftmd = sft_q; state_d = S_WB; end
          CLS_ITYPE: begin alu_src = 1'b1; alu_op = ALU_ITYPE; state_d = S_WB; end
          CLS_BEQ, CLS_BNE: begin
            alu_op   = ALU_SUB;
            pc_src   = PC_BRANCH;
            pc_write = (cls == CLS_BEQ) ? zero : !zero;
            state_d  = S_IF;
          end
          CLS_LW, CLS_SW: begin alu_src = 1'b1; state_d = S_MEM; end
          default:   state_d = S_IF;
        endcase
      end
      S_MEM: begin
        mem_read  = (cls == CLS_LW);
        mem_write = (cls == CLS_SW);
        if (mem_ready) state_d = (cls == CLS_LW) ? S_WB : S_IF;
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (cls == CLS_RTYPE) ? DST_RD : DST_RT;
        mem_to_reg = (cls == CLS_LW);
        state_d    = S_IF;
      end
      default: state_d = S_IF;
    endcase
    // Reset silences every strobe immediately, abandoning any MEM access.
    if (reset) begin
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = PC_PLUS4;
      reg_write  = 1'b0;
      reg_dst    = DST_RT;
      mem_to_reg = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      alu_src    = 1'b0;
      alu_op     = ALU_ADD;
      sftmd      = 1'b0;
    end
  end

  assign state       = reset ? 3'd0 : state_q;
  assign instr_done  = !reset && (state_d == S_IF);
  assign illegal     = !reset && illegal_q;
  assign mem_timeout = !reset && timeout_q;

endmodule

// File: tb/tb_multicycle_ctrl32.sv
// Self-checking bench for multicycle_ctrl32: per-instruction behavioural
// model feeding an expectation queue, checked every cycle on the falling edge.
module tb_multicycle_ctrl32;

  localparam int MAXW = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = '0, funct = '0;
  logic       zero = 1'b0, mem_ready = 1'b0;

  logic [2:0] state;
  logic       ir_write, pc_write, reg_write, mem_to_reg, mem_read, mem_write;
  logic       alu_src, sftmd, instr_done, illegal, mem_timeout;
  logic [1:0] pc_src, reg_dst, alu_op;

  multicycle_ctrl32 #(.MEM_WAIT_MAX(MAXW)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .state(state), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .mem_read(mem_read), .mem_write(mem_write), .alu_src(alu_src), .alu_op(alu_op),
    .sftmd(sftmd), .instr_done(instr_done), .illegal(illegal), .mem_timeout(mem_timeout)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0] st;
    logic       ir_write, pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic       mem_to_reg, mem_read, mem_write, alu_src;
    logic [1:0] alu_op;
    logic       sftmd, instr_done, illegal, mem_timeout;
  } outs_t;

  typedef enum {K_R, K_I, K_J, K_JAL, K_JR, K_BEQ, K_BNE, K_LW, K_SW, K_ILL} kind_t;

  typedef struct {
    outs_t v;
    string tag;
  } exp_t;

  outs_t act;
  assign act = {state, ir_write, pc_write, pc_src, reg_write, reg_dst, mem_to_reg,
                mem_read, mem_write, alu_src, alu_op, sftmd, instr_done, illegal,
                mem_timeout};

  exp_t  expq[$];
  exp_t  cmp_e;
  outs_t trace[$];
  int    total = 0;
  int    bad = 0;
  logic  ill_m = 1'b0;
  logic  to_m = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  always @(negedge clock) begin
    if (expq.size() > 0) begin
      cmp_e = expq.pop_front();
      check(cmp_e.tag, 32'(act), 32'(cmp_e.v));
    end
  end

  // Outputs for one cycle of an instruction of kind k in state st.
  function automatic outs_t model(input kind_t k, input logic [2:0] st, input logic z,
                                  input logic last_mem, input logic sft);
    outs_t o;
    o    = '0;
    o.st = st;
    case (st)
      3'd0: begin o.ir_write = 1'b1; o.pc_write = 1'b1; end
      3'd1: case (k)
        K_J:   begin o.pc_write = 1'b1; o.pc_src = 2'd2; o.instr_done = 1'b1; end
        K_JAL: begin
          o.pc_write = 1'b1; o.pc_src = 2'd2; o.reg_write = 1'b1; o.reg_dst = 2'd2;
          o.instr_done = 1'b1;
        end
        K_JR:  begin o.pc_write = 1'b1; o.pc_src = 2'd3; o.instr_done = 1'b1; end
        K_ILL: o.instr_done = 1'b1;
        default: ;
      endcase
      3'd2: case (k)
        K_R:   begin o.alu_op = 2'b10; o.sftmd = sft; end
        K_I:   begin o.alu_src = 1'b1; o.alu_op = 2'b11; end
        K_BEQ: begin o.alu_op = 2'b01; o.pc_src = 2'd1; o.pc_write = z;  o.instr_done = 1'b1; end
        K_BNE: begin o.alu_op = 2'b01; o.pc_src = 2'd1; o.pc_write = !z; o.instr_done = 1'b1; end
        K_LW, K_SW: o.alu_src = 1'b1;
        default: ;
      endcase
      3'd3: begin
        o.mem_read   = (k == K_LW);
        o.mem_write  = (k == K_SW);
        o.instr_done = (k == K_SW) && last_mem;
      end
      3'd4: begin
        o.reg_write  = 1'b1;
        o.reg_dst    = (k == K_R) ? 2'd1 : 2'd0;
        o.mem_to_reg = (k == K_LW);
        o.instr_done = 1'b1;
      end
      default: ;
    endcase
    return o;
  endfunction

  // Runs one instruction (or its first 'limit' cycles when limit >= 0).
  task automatic run(input string name, input logic [5:0] op, input logic [5:0] fn,
                     input kind_t k, input logic z, input int waits, input int limit);
    logic [2:0] seq[$];
    int         midx;
    logic       sft;
    exp_t       e;
    midx = 0;
    seq  = {3'd0, 3'd1};
    if (k inside {K_BEQ, K_BNE, K_R, K_I, K_LW, K_SW}) seq.push_back(3'd2);
    if (k inside {K_LW, K_SW}) for (int i = 0; i <= waits; i++) seq.push_back(3'd3);
    if (k inside {K_R, K_I, K_LW}) seq.push_back(3'd4);
    sft = (k == K_R) && (fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07});
    trace.delete();
    for (int c = 0; c < seq.size() && (limit < 0 || c < limit); c++) begin
      @(posedge clock);
      #1;
      reset  = 1'b0;
      opcode = op;
      funct  = fn;
      zero   = z;
      if (seq[c] == 3'd3) begin
        mem_ready = (midx == waits);
        if (midx >= MAXW) to_m = 1'b1;
      end else begin
        mem_ready = 1'b1;
      end
      e.v             = model(k, seq[c], z, (seq[c] == 3'd3) && (midx == waits), sft);
      e.v.illegal     = ill_m;
      e.v.mem_timeout = to_m;
      e.tag           = $sformatf("%s c%0d", name, c);
      expq.push_back(e);
      if (seq[c] == 3'd1 && k == K_ILL) ill_m = 1'b1;
      if (seq[c] == 3'd3) midx++;
      @(negedge clock);
      #1 trace.push_back(act);
    end
  endtask

  task automatic do_reset(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      reset     = 1'b1;
      mem_ready = 1'b0;
      e.v       = '0;
      e.tag     = $sformatf("reset c%0d", i);
      expq.push_back(e);
      @(negedge clock);
      #1 trace.push_back(act);
    end
    ill_m = 1'b0;
    to_m  = 1'b0;
  endtask

  initial begin
    trace.delete();
    do_reset(3);
    check("reset outputs", 32'(trace[2]), 32'd0);

    run("add", 6'h00, 6'h20, K_R, 1'b0, 0, -1);
    check("add st0", 32'(trace[0].st), 32'd0);
    check("add ir_write", 32'(trace[0].ir_write), 32'd1);
    check("add st3", 32'(trace[3].st), 32'd4);
    check("add wb reg_dst", 32'(trace[3].reg_dst), 32'd1);
    check("add ex reg_write", 32'(trace[2].reg_write), 32'd0);

    run("lw", 6'h23, 6'h00, K_LW, 1'b0, 2, -1);
    check("lw mem_read c5", 32'(trace[5].mem_read), 32'd1);
    check("lw st c6", 32'(trace[6].st), 32'd4);
    check("lw mem_to_reg", 32'(trace[6].mem_to_reg), 32'd1);

    run("beq z1", 6'h04, 6'h00, K_BEQ, 1'b1, 0, -1);
    check("beq pc_write", 32'(trace[2].pc_write), 32'd1);
    check("beq pc_src", 32'(trace[2].pc_src), 32'd1);
    run("bne z1", 6'h05, 6'h00, K_BNE, 1'b1, 0, -1);
    check("bne pc_write", 32'(trace[2].pc_write), 32'd0);
    run("beq z0", 6'h04, 6'h00, K_BEQ, 1'b0, 0, -1);
    run("bne z0", 6'h05, 6'h00, K_BNE, 1'b0, 0, -1);

    run("jal", 6'h03, 6'h00, K_JAL, 1'b0, 0, -1);
    check("jal pc_src", 32'(trace[1].pc_src), 32'd2);
    check("jal reg_dst", 32'(trace[1].reg_dst), 32'd2);
    run("jr", 6'h00, 6'h08, K_JR, 1'b0, 0, -1);
    check("jr pc_src", 32'(trace[1].pc_src), 32'd3);
    run("j", 6'h02, 6'h00, K_J, 1'b0, 0, -1);

    run("addi", 6'h08, 6'h15, K_I, 1'b0, 0, -1);
    run("lui", 6'h0f, 6'h00, K_I, 1'b1, 0, -1);
    run("sll", 6'h00, 6'h00, K_R, 1'b0, 0, -1);
    check("sll sftmd", 32'(trace[2].sftmd), 32'd1);
    run("srav", 6'h00, 6'h07, K_R, 1'b0, 0, -1);
    run("sw w0", 6'h2b, 6'h00, K_SW, 1'b0, 0, -1);

    run("ill 3f", 6'h3f, 6'h00, K_ILL, 1'b0, 0, -1);
    run("add after ill", 6'h00, 6'h20, K_R, 1'b0, 0, -1);
    check("illegal sticky", 32'(trace[0].illegal), 32'd1);
    run("ill 10", 6'h10, 6'h00, K_ILL, 1'b0, 0, -1);
    run("add 2", 6'h00, 6'h21, K_R, 1'b0, 0, -1);

    run("sw timeout", 6'h2b, 6'h00, K_SW, 1'b0, MAXW + 2, -1);
    check("sw timeout flag", 32'(trace[trace.size()-1].mem_timeout), 32'd1);
    check("sw timeout mem_write", 32'(trace[trace.size()-1].mem_write), 32'd1);
    run("add after to", 6'h00, 6'h20, K_R, 1'b0, 0, -1);

    run("sw abort", 6'h2b, 6'h00, K_SW, 1'b0, 50, 5);
    do_reset(1);
    check("abort mem_write pre", 32'(trace[3].mem_write), 32'd1);
    check("abort mem_write rst", 32'(trace[5].mem_write), 32'd0);
    run("add after abort", 6'h00, 6'h20, K_R, 1'b0, 0, -1);
    check("abort next IF", 32'(trace[0].st), 32'd0);
    check("flags cleared", 32'({trace[0].illegal, trace[0].mem_timeout}), 32'd0);

    @(posedge clock);
    #1;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL queue drain got=%0d want=0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
